// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store control unit:
// access sizes, FSM states, fault causes and RV32I load/store funct3 codes.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FAULT  = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_RANGE      = 2'd2,
    CAUSE_ILLEGAL    = 2'd3
  } lsu_cause_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input mem_size_t size);
    case (size)
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the execute-stage handshake and the data-memory port.
// The LSU uses the slave view; the core/memory side uses the master view.
interface lsu_ctrl_if;
  import lsu_ctrl_pkg::*;

  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_is_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_base;
  logic [31:0] lsu_offset;
  logic [31:0] lsu_store_data;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_load_data;
  logic        lsu_fault;
  lsu_cause_t  lsu_fault_cause;
  logic [31:0] lsu_fault_addr;

  logic        dmem_req;
  logic        dmem_wr_en;
  mem_size_t   dmem_data_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wr_data;
  logic        dmem_zero_extend;
  logic [31:0] dmem_rd_data;

  modport slave (
    input  lsu_valid, lsu_is_store, lsu_funct3, lsu_base, lsu_offset,
           lsu_store_data, dmem_rd_data,
    output lsu_ready, lsu_busy, lsu_done, lsu_load_data, lsu_fault,
           lsu_fault_cause, lsu_fault_addr, dmem_req, dmem_wr_en,
           dmem_data_size, dmem_addr, dmem_wr_data, dmem_zero_extend
  );

  modport master (
    output lsu_valid, lsu_is_store, lsu_funct3, lsu_base, lsu_offset,
           lsu_store_data, dmem_rd_data,
    input  lsu_ready, lsu_busy, lsu_done, lsu_load_data, lsu_fault,
           lsu_fault_cause, lsu_fault_addr, dmem_req, dmem_wr_en,
           dmem_data_size, dmem_addr, dmem_wr_data, dmem_zero_extend
  );

endinterface

// File: rtl/lsu_ctrl_decode.sv
// Combinational decode of funct3 and effective address into access size,
// zero-extension and the highest-priority fault cause.
module lsu_ctrl_decode
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [31:0] ea_i,
  output mem_size_t   size_o,
  output logic        zero_extend_o,
  output lsu_cause_t  cause_o
);

  localparam logic [32:0] ADDR_LIMIT = (33'd1 << ADDR_WIDTH) - 33'd1;

  logic        illegal;
  logic        misaligned;
  logic [32:0] last_byte;

  always_comb begin
    size_o        = SIZE_BYTE;
    zero_extend_o = 1'b0;
    illegal       = 1'b0;
    case (funct3_i)
      F3_B: size_o = SIZE_BYTE;
      F3_H: size_o = SIZE_HALF;
      F3_W: size_o = SIZE_WORD;
      F3_BU: begin
        size_o        = SIZE_BYTE;
        zero_extend_o = 1'b1;
        illegal       = is_store_i;
      end
      F3_HU: begin
        size_o        = SIZE_HALF;
        zero_extend_o = 1'b1;
        illegal       = is_store_i;
      end
      default: illegal = 1'b1;
    endcase

    misaligned = ((size_o == SIZE_HALF) && ea_i[0]) ||
                 ((size_o == SIZE_WORD) && (ea_i[1:0] != 2'b00));

    // 33-bit sum so an access straddling 2^32 still reads as out of range.
    last_byte = {1'b0, ea_i} + {30'd0, size_bytes(size_o)} - 33'd1;

    if (illegal) begin
      cause_o = CAUSE_ILLEGAL;
    end else if (misaligned) begin
      cause_o = CAUSE_MISALIGNED;
    end else if (last_byte > ADDR_LIMIT) begin
      cause_o = CAUSE_RANGE;
    end else begin
      cause_o = CAUSE_NONE;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control unit: accepts one op from execute, checks it, drives the
// data-memory port for ACCESS_CYCLES cycles and reports load data or a fault.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  lsu_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] wdata_q, wdata_d;
  mem_size_t   size_q, size_d;
  logic        zx_q, zx_d;
  logic        is_store_q, is_store_d;
  lsu_cause_t  cause_q, cause_d;
  lsu_cause_t  fault_cause_q, fault_cause_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] load_data_q, load_data_d;

  logic [31:0] ea_calc;
  mem_size_t   dec_size;
  logic        dec_zx;
  lsu_cause_t  dec_cause;
  logic        last_cycle;

  assign ea_calc    = bus.lsu_base + bus.lsu_offset;
  assign last_cycle = (cnt_q == LAST_CNT);

  lsu_ctrl_decode #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .funct3_i      (bus.lsu_funct3),
    .is_store_i    (bus.lsu_is_store),
    .ea_i          (ea_calc),
    .size_o        (dec_size),
    .zero_extend_o (dec_zx),
    .cause_o       (dec_cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ea_q          <= '0;
      wdata_q       <= '0;
      size_q        <= SIZE_BYTE;
      zx_q          <= 1'b0;
      is_store_q    <= 1'b0;
      cause_q       <= CAUSE_NONE;
      fault_cause_q <= CAUSE_NONE;
      fault_addr_q  <= '0;
      load_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ea_q          <= ea_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      zx_q          <= zx_d;
      is_store_q    <= is_store_d;
      cause_q       <= cause_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
      load_data_q   <= load_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ea_d          = ea_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    zx_d          = zx_q;
    is_store_d    = is_store_q;
    cause_d       = cause_q;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    load_data_d   = load_data_q;

    bus.lsu_ready        = 1'b0;
    bus.lsu_busy         = 1'b0;
    bus.lsu_done         = 1'b0;
    bus.lsu_fault        = 1'b0;
    bus.dmem_req         = 1'b0;
    bus.dmem_wr_en       = 1'b0;
    bus.dmem_data_size   = SIZE_BYTE;
    bus.dmem_addr        = '0;
    bus.dmem_wr_data     = '0;
    bus.dmem_zero_extend = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.lsu_ready = 1'b1;
        if (bus.lsu_valid) begin
          ea_d       = ea_calc;
          wdata_d    = bus.lsu_store_data;
          size_d     = dec_size;
          zx_d       = dec_zx;
          is_store_d = bus.lsu_is_store;
          cause_d    = dec_cause;
          cnt_d      = '0;
          state_d    = (dec_cause != CAUSE_NONE) ? FAULT : ACCESS;
        end
      end
      ACCESS: begin
        bus.lsu_busy         = 1'b1;
        bus.dmem_req         = 1'b1;
        bus.dmem_data_size   = size_q;
        bus.dmem_addr        = ea_q;
        bus.dmem_wr_data     = wdata_q;
        bus.dmem_zero_extend = zx_q;
        // Write strobe only on the last cycle so memory sees a single write.
        bus.dmem_wr_en       = is_store_q && last_cycle;
        cnt_d                = cnt_q + 4'd1;
        if (last_cycle) begin
          if (!is_store_q) begin
            load_data_d = bus.dmem_rd_data;
          end
          state_d = DONE;
        end
      end
      FAULT: begin
        bus.lsu_busy  = 1'b1;
        fault_cause_d = cause_q;
        fault_addr_d  = ea_q;
        state_d       = DONE;
      end
      DONE: begin
        bus.lsu_busy  = 1'b1;
        bus.lsu_done  = 1'b1;
        bus.lsu_fault = (cause_q != CAUSE_NONE);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.lsu_load_data   = load_data_q;
  assign bus.lsu_fault_cause = fault_cause_q;
  assign bus.lsu_fault_addr  = fault_addr_q;

endmodule
